muldiv_unit: RTL

//  Iterative RV32M multiply/divide unit sitting beside the ALU in the EX stage.

---
 rtl/muldiv_unit.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring shift-subtract divide. Each op
// takes 32 CALC steps, followed by one FIXUP cycle for sign correction and
// word selection. Divide-by-zero and signed overflow are answered straight
// from IDLE.
// Optional feature macro: MULDIV_EARLY_OUT_EN. When it is defined, a multiply
// leaves CALC as soon as the multiplier bits not yet consumed are all zero.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Architectural state
  state_e             state;
  op_e                op;
  logic [CNT_W-1:0]   cnt;
  logic               neg_res;   // product or quotient must be negated
  logic               neg_rem;   // remainder takes the dividend's sign

  // Multiply datapath
  logic [2*WIDTH-1:0] acc;       // 64-bit unsigned product accumulator
  logic [2*WIDTH-1:0] mcand;     // |rs1|, shifted left once per step
  logic [WIDTH-1:0]   mplier;    // |rs2|, shifted right once per step

  // Divide datapath
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rem;       // partial remainder (always below divisor)
  logic [WIDTH-1:0]   quo;       // dividend bits shift out, quotient bits shift in

  // Request decode
  op_e                req_op;
  logic               rs1_signed;
  logic               rs2_signed;
  logic               rs1_neg;
  logic               rs2_neg;
  logic [WIDTH-1:0]   rs1_abs;
  logic [WIDTH-1:0]   rs2_abs;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   special_result;

  // Step and fixup results
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     rem_shift;  // 33-bit shifted partial remainder
  logic [WIDTH:0]     rem_diff;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic               mul_early;
  logic               calc_last;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_result;

  assign req_op = op_e'(funct3);

  // Signedness and absolute values of the incoming operands.
  // The low word of mul does not depend on signedness. Treating its operands
  // as signed keeps small negative multipliers short when early-out is enabled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rs1_signed = 1'b0;
    rs2_signed = 1'b0;
    unique case (req_op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b1;
      end
      OP_MULHSU: rs1_signed = 1'b1;
      default: ;
    endcase
    rs1_neg = rs1_signed & rs1_data[WIDTH-1];
    rs2_neg = rs2_signed & rs2_data[WIDTH-1];
    rs1_abs = rs1_neg ? -rs1_data : rs1_data;
    rs2_abs = rs2_neg ? -rs2_data : rs2_data;
  end

  // Divide corner cases that bypass the iteration entirely.
  always_comb begin
    div_zero = req_op[2] && (rs2_data == '0);
    div_ovf  = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
               (rs1_data == INT_MIN) && (rs2_data == '1);
    special_result = '0;
    if (div_zero)
      special_result = req_op[1] ? rs1_data : '1;
    else if (div_ovf)
      special_result = req_op[1] ? '0 : INT_MIN;
  end

  // One radix-2 step of multiply and of restoring divide.
  always_comb begin
    acc_step  = mplier[0] ? (acc + mcand) : acc;
    rem_shift = {1'b0, rem, quo[WIDTH-1]};
    rem_shift = {rem, quo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    if (!rem_diff[WIDTH]) begin
      rem_step = rem_diff[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = rem_shift[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b0};
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Multiply may stop once the multiplier bits not yet consumed are all zero.
  assign mul_early = !op[2] && (mplier[WIDTH-1:1] == '0);
`else
  assign mul_early = 1'b0;
`endif

  assign calc_last = (cnt == CNT_LAST) || mul_early;

  // Sign correction and selection of the result word.
  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -quo : quo;
    rem_fix  = neg_rem ? -rem : rem;
    unique case (op)
      OP_MUL:                      fix_result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             fix_result = quo_fix;
      default:                     fix_result = rem_fix;
    endcase
  end

  // Control FSM and datapath registers. All outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the datapath registers are reset too, so no X reaches the result mux after reset.
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      result     <= '0;
      cnt        <= '0;
      op         <= OP_MUL;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      divisor    <= '0;
      rem        <= '0;
      quo        <= '0;
    end else if (flush) begin
      // The operation is killed. The datapath keeps its contents.
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op        <= req_op;
            neg_res   <= rs1_neg ^ rs2_neg;
            neg_rem   <= rs1_neg;
            cnt       <= '0;
            req_ready <= 1'b0;
            if (div_zero || div_ovf) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              result     <= special_result;
            end else begin
              state   <= CALC;
              acc     <= '0;
              mcand   <= {{WIDTH{1'b0}}, rs1_abs};
              mplier  <= rs2_abs;
              divisor <= rs2_abs;
              rem     <= '0;
              quo     <= rs1_abs;
            end
          end
        end
        CALC: begin
          if (op[2]) begin
            rem <= rem_step;
            quo <= quo_step;
          end else begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          if (calc_last) begin
            state <= FIXUP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIXUP: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          result     <= fix_result;
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
